// File: rtl/masked_mul_sched_if.sv
// Handshake bundle for masked_mul_sched: two requesters, a randomness stream and one result stream.
// The scheduler takes the slave modport and its environment takes the master modport.
interface masked_mul_sched_if #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned BIT_WIDTH  = 4
);
  localparam int unsigned NUM_QUAD  = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int unsigned RAND_BITS = 2 * NUM_QUAD * BIT_WIDTH;

  logic [1:0]                                 in_req_valid;
  logic [1:0]                                 out_req_ready;
  logic [1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]  in_req_a;
  logic [1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0]  in_req_b;
  logic                                       in_rand_valid;
  logic                                       out_rand_ready;
  logic [RAND_BITS-1:0]                       in_rand;
  logic                                       out_res_valid;
  logic                                       in_res_ready;
  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]       out_res_c;
  logic                                       out_res_id;
  logic                                       out_busy;

  modport master (
    output in_req_valid, in_req_a, in_req_b, in_rand_valid, in_rand, in_res_ready,
    input  out_req_ready, out_rand_ready, out_res_valid, out_res_c, out_res_id, out_busy
  );

  modport slave (
    input  in_req_valid, in_req_a, in_req_b, in_rand_valid, in_rand, in_res_ready,
    output out_req_ready, out_rand_ready, out_res_valid, out_res_c, out_res_id, out_busy
  );
endinterface

// File: rtl/masked_mul_sched.sv
// Two-requester scheduler around one HPC3 masked GF(2^n) multiplier (1-cycle register stage).
// Macro MUL_SCHED_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority.
module masked_hpc3_opt_mul #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned BIT_WIDTH  = 4
) (
  input  logic                                                   in_clock,
  input  logic                                                   in_reset,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                   in_a,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                   in_b,
  input  logic [NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0]       in_r,
  input  logic [NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0]       in_p,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                   out_c
);
  // Reduction polynomial low terms: x^n+x+1 except n=5 (x^5+x^2+1) and n=8 (AES).
  localparam int unsigned POLY_INT = (BIT_WIDTH == 8) ? 32'h1b :
                                     (BIT_WIDTH == 5) ? 32'h05 : 32'h03;
  localparam logic [BIT_WIDTH-1:0] POLY = POLY_INT[BIT_WIDTH-1:0];

  function automatic logic [BIT_WIDTH-1:0] gf_mul(input logic [BIT_WIDTH-1:0] x,
                                                  input logic [BIT_WIDTH-1:0] y);
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] sh;
    acc = '0;
    sh  = x;
    for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = sh[BIT_WIDTH-1] ? ((sh << 1) ^ POLY) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * NUM_SHARES - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  logic [BIT_WIDTH-1:0] u_d [NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] u_q [NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] w_d [NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] w_q [NUM_SHARES][NUM_SHARES];

  // Pair (i,j) and (j,i) share r and p so the p terms cancel in the share sum.
  always_comb begin
    int unsigned k;
    logic [BIT_WIDTH-1:0] r;
    logic [BIT_WIDTH-1:0] p;
    k = 0;
    r = '0;
    p = '0;
    for (int unsigned i = 0; i < NUM_SHARES; i++) begin
      for (int unsigned j = 0; j < NUM_SHARES; j++) begin
        if (i == j) begin
          u_d[i][j] = gf_mul(in_a[i], in_b[i]);
          w_d[i][j] = '0;
        end else begin
          k = pair_idx(i, j);
          r = in_r[k*BIT_WIDTH +: BIT_WIDTH];
          p = in_p[k*BIT_WIDTH +: BIT_WIDTH];
          u_d[i][j] = gf_mul(in_a[i], in_b[j] ^ r);
          w_d[i][j] = gf_mul(in_a[i], r) ^ p;
        end
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int unsigned i = 0; i < NUM_SHARES; i++) begin
        for (int unsigned j = 0; j < NUM_SHARES; j++) begin
          u_q[i][j] <= '0;
          w_q[i][j] <= '0;
        end
      end
    end else begin
      u_q <= u_d;
      w_q <= w_d;
    end
  end

  always_comb begin
    out_c = '0;
    for (int unsigned i = 0; i < NUM_SHARES; i++) begin
      for (int unsigned j = 0; j < NUM_SHARES; j++) begin
        out_c[i] = out_c[i] ^ u_q[i][j] ^ w_q[i][j];
      end
    end
  end
endmodule

module masked_mul_sched #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned BIT_WIDTH  = 4,
  parameter int unsigned RAND_DEPTH = 4
) (
  input logic               in_clock,
  input logic               in_reset,
  masked_mul_sched_if.slave bus
);
  localparam int unsigned NUM_QUAD  = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int unsigned RAND_BITS = 2 * NUM_QUAD * BIT_WIDTH;
  localparam int unsigned HALF_BITS = NUM_QUAD * BIT_WIDTH;
  localparam int unsigned PTR_W     = $clog2(RAND_DEPTH);

  typedef logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] shares_t;

  logic [RAND_BITS-1:0] rand_mem_q [RAND_DEPTH];
  logic [PTR_W-1:0]     rand_wr_q, rand_rd_q;
  logic [PTR_W:0]       rand_cnt_q, rand_cnt_d;
  logic                 rand_full, rand_empty, rand_push, rand_pop;
  logic [RAND_BITS-1:0] rand_head;

  shares_t              res_c_q [2];
  logic [1:0]           res_id_q;
  logic                 res_wr_q, res_rd_q;
  logic [1:0]           res_cnt_q, res_cnt_d;
  logic                 res_valid, res_push, res_pop;
  logic [1:0]           occ;

  logic                 inf_v_q, inf_id_q;
  logic                 issue, grant_id;
  shares_t              mul_a, mul_b, mul_c;
  logic [HALF_BITS-1:0] mul_r, mul_p;

  assign rand_full  = (rand_cnt_q == (PTR_W+1)'(RAND_DEPTH));
  assign rand_empty = (rand_cnt_q == '0);
  assign rand_push  = bus.in_rand_valid && !rand_full;
  assign rand_pop   = issue;
  assign rand_head  = rand_mem_q[rand_rd_q];

  assign res_valid = (res_cnt_q != 2'd0);
  assign res_pop   = res_valid && bus.in_res_ready;
  assign res_push  = inf_v_q;

  // Slots still owned once this cycle's pop retires; at most two may be outstanding.
  assign occ   = 2'(inf_v_q) + res_cnt_q - 2'(res_pop);
  assign issue = (|bus.in_req_valid) && !rand_empty && (occ < 2'd2);

`ifdef MUL_SCHED_ROUND_ROBIN_EN
  logic prio_q;
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset)  prio_q <= 1'b0;
    else if (issue) prio_q <= ~grant_id;
  end
  assign grant_id = bus.in_req_valid[prio_q] ? prio_q : ~prio_q;
`else
  assign grant_id = ~bus.in_req_valid[0];
`endif

  assign bus.out_req_ready  = issue ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.out_rand_ready = in_reset && !rand_full;

  assign mul_a = issue ? bus.in_req_a[grant_id] : '0;
  assign mul_b = issue ? bus.in_req_b[grant_id] : '0;
  assign mul_r = issue ? rand_head[HALF_BITS-1:0] : '0;
  assign mul_p = issue ? rand_head[RAND_BITS-1:HALF_BITS] : '0;

  masked_hpc3_opt_mul #(
    .NUM_SHARES (NUM_SHARES),
    .BIT_WIDTH  (BIT_WIDTH)
  ) u_mul (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_a     (mul_a),
    .in_b     (mul_b),
    .in_r     (mul_r),
    .in_p     (mul_p),
    .out_c    (mul_c)
  );

  always_comb begin
    rand_cnt_d = rand_cnt_q;
    unique case ({rand_push, rand_pop})
      2'b10:   rand_cnt_d = rand_cnt_q + 1'b1;
      2'b01:   rand_cnt_d = rand_cnt_q - 1'b1;
      default: rand_cnt_d = rand_cnt_q;
    endcase
  end

  always_comb begin
    res_cnt_d = res_cnt_q;
    unique case ({res_push, res_pop})
      2'b10:   res_cnt_d = res_cnt_q + 2'd1;
      2'b01:   res_cnt_d = res_cnt_q - 2'd1;
      default: res_cnt_d = res_cnt_q;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (rand_push) rand_mem_q[rand_wr_q] <= bus.in_rand;
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      rand_wr_q  <= '0;
      rand_rd_q  <= '0;
      rand_cnt_q <= '0;
      inf_v_q    <= 1'b0;
      inf_id_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_rd_q   <= 1'b0;
      res_cnt_q  <= 2'd0;
      res_id_q   <= 2'b00;
      res_c_q[0] <= '0;
      res_c_q[1] <= '0;
    end else begin
      if (rand_push) rand_wr_q <= rand_wr_q + PTR_W'(1);
      if (rand_pop)  rand_rd_q <= rand_rd_q + PTR_W'(1);
      rand_cnt_q <= rand_cnt_d;
      inf_v_q    <= issue;
      if (issue) inf_id_q <= grant_id;
      if (res_push) begin
        res_c_q[res_wr_q]  <= mul_c;
        res_id_q[res_wr_q] <= inf_id_q;
        res_wr_q           <= ~res_wr_q;
      end
      if (res_pop) res_rd_q <= ~res_rd_q;
      res_cnt_q <= res_cnt_d;
    end
  end

  assign bus.out_res_valid = res_valid;
  assign bus.out_res_c     = res_valid ? res_c_q[res_rd_q] : '0;
  assign bus.out_res_id    = res_valid && res_id_q[res_rd_q];
  assign bus.out_busy      = inf_v_q || res_valid;
endmodule

// File: tb/tb_masked_mul_sched.sv
// Directed and randomized bench for masked_mul_sched with a transaction-level reference model.
// Build with MUL_SCHED_ROUND_ROBIN_EN defined to check the round-robin arbiter.
module tb_masked_mul_sched;
  localparam int NS    = 2;
  localparam int BW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic in_reset = 1'b0;
  always #5 clk = ~clk;

  masked_mul_sched_if #(.NUM_SHARES(NS), .BIT_WIDTH(BW)) bus ();

  masked_mul_sched #(
    .NUM_SHARES (NS),
    .BIT_WIDTH  (BW),
    .RAND_DEPTH (DEPTH)
  ) dut (
    .in_clock (clk),
    .in_reset (in_reset),
    .bus      (bus)
  );

  typedef struct {
    logic           id;
    logic [BW-1:0]  prod;
    int             t;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rand_cnt_m = 0;
  logic       last_m = 1'b1;
  logic [1:0] seen_ready;
  int         dut_issues = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Field product by schoolbook multiply then long division by x^4+x+1.
  function automatic logic [BW-1:0] gf_ref(input logic [BW-1:0] x, input logic [BW-1:0] y);
    logic [2*BW-2:0] prod;
    logic [2*BW-2:0] poly;
    prod = '0;
    poly = 7'h13;
    for (int i = 0; i < BW; i++) if (y[i]) prod = prod ^ ((2*BW-1)'(x) << i);
    for (int i = 2*BW-2; i >= BW; i--) if (prod[i]) prod = prod ^ (poly << (i - BW));
    return prod[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] fold(input logic [NS-1:0][BW-1:0] s);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v = v ^ s[i];
    return v;
  endfunction

  function automatic logic pick(input logic [1:0] v);
`ifdef MUL_SCHED_ROUND_ROBIN_EN
    if (v[!last_m]) return !last_m;
    return last_m;
`else
    if (v[0]) return 1'b0;
    return 1'b1;
`endif
  endfunction

  task automatic set_idle();
    bus.in_req_valid  = 2'b00;
    bus.in_req_a      = '0;
    bus.in_req_b      = '0;
    bus.in_rand_valid = 1'b0;
    bus.in_rand       = '0;
    bus.in_res_ready  = 1'b1;
  endtask

  task automatic rand_ops();
    bus.in_req_a = 16'($urandom());
    bus.in_req_b = 16'($urandom());
    bus.in_rand  = 8'($urandom());
  endtask

  task automatic do_cycle();
    logic       exp_valid, pop, exp_issue, gid;
    logic [1:0] exp_ready;
    #1;
    exp_valid = (q.size() > 0) && (q[0].t + 2 <= cyc);
    pop       = exp_valid && bus.in_res_ready;
    gid       = pick(bus.in_req_valid);
    exp_issue = (|bus.in_req_valid) && (rand_cnt_m > 0) && ((q.size() - int'(pop)) < 2);
    exp_ready = !exp_issue ? 2'b00 : (gid ? 2'b10 : 2'b01);
    chk("req_ready", 32'(bus.out_req_ready), 32'(exp_ready));
    chk("rand_ready", 32'(bus.out_rand_ready), 32'(rand_cnt_m < DEPTH));
    chk("res_valid", 32'(bus.out_res_valid), 32'(exp_valid));
    chk("busy", 32'(bus.out_busy), 32'(q.size() > 0));
    if (exp_valid) begin
      chk("res_id", 32'(bus.out_res_id), 32'(q[0].id));
      chk("res_prod", 32'(fold(bus.out_res_c)), 32'(q[0].prod));
    end
    seen_ready = bus.out_req_ready;
    if (|seen_ready) dut_issues++;
    if (pop) void'(q.pop_front());
    if (exp_issue) begin
      q.push_back('{gid, gf_ref(fold(bus.in_req_a[gid]), fold(bus.in_req_b[gid])), cyc});
      last_m = gid;
    end
    rand_cnt_m = rand_cnt_m + ((bus.in_rand_valid && rand_cnt_m < DEPTH) ? 1 : 0)
                 - (exp_issue ? 1 : 0);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_idle();
    in_reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.out_req_ready), 32'd0);
    chk("rst_rand_ready", 32'(bus.out_rand_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.out_res_valid), 32'd0);
    chk("rst_res_c", 32'(bus.out_res_c), 32'd0);
    chk("rst_res_id", 32'(bus.out_res_id), 32'd0);
    chk("rst_busy", 32'(bus.out_busy), 32'd0);
    q.delete();
    rand_cnt_m = 0;
    last_m = 1'b1;
    @(posedge clk);
    #1;
    in_reset = 1'b1;
  endtask

  initial begin
    logic [7:0] gseq;
`ifdef MUL_SCHED_ROUND_ROBIN_EN
    gseq = 8'b10_01_10_01;
`else
    gseq = 8'b01_01_01_01;
`endif
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Single operation: 3 * 5 in GF(16) = 0xF, latency 2.
    bus.in_rand_valid = 1'b1;
    bus.in_rand = 8'($urandom());
    do_cycle();
    bus.in_rand_valid = 1'b0;
    bus.in_req_valid = 2'b01;
    bus.in_req_a[0] = 8'h03;
    bus.in_req_b[0] = 8'h05;
    do_cycle();
    chk("single_grant", 32'(seen_ready), 32'h1);
    set_idle();
    #1;
    chk("single_lat_t1", 32'(bus.out_res_valid), 32'd0);
    do_cycle();
    #1;
    chk("single_valid_t2", 32'(bus.out_res_valid), 32'd1);
    chk("single_id", 32'(bus.out_res_id), 32'd0);
    chk("single_prod", 32'(fold(bus.out_res_c)), 32'hf);
    do_cycle();

    // Arbitration with a full randomness FIFO.
    apply_reset();
    bus.in_rand_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_rand = 8'($urandom());
      do_cycle();
    end
    chk("fifo_full", 32'(bus.out_rand_ready), 32'd0);
    bus.in_rand_valid = 1'b0;
    bus.in_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      rand_ops();
      do_cycle();
      chk($sformatf("arb_grant%0d", k), 32'(seen_ready), 32'(gseq[2*k +: 2]));
    end
    set_idle();
    repeat (3) do_cycle();

    // Empty randomness FIFO blocks issue until one word arrives.
    dut_issues = 0;
    bus.in_req_valid = 2'b01;
    rand_ops();
    repeat (3) do_cycle();
    chk("starve_no_issue", 32'(dut_issues), 32'd0);
    bus.in_rand_valid = 1'b1;
    do_cycle();
    bus.in_rand_valid = 1'b0;
    repeat (4) do_cycle();
    chk("starve_one_issue", 32'(dut_issues), 32'd1);
    set_idle();
    repeat (3) do_cycle();

    // Result backpressure: two outstanding then 1/cycle.
    dut_issues = 0;
    bus.in_req_valid = 2'b01;
    bus.in_rand_valid = 1'b1;
    bus.in_res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      do_cycle();
    end
    chk("stall_issues", 32'(dut_issues), 32'd2);
    dut_issues = 0;
    bus.in_res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      do_cycle();
    end
    chk("resume_issues", 32'(dut_issues), 32'd6);
    set_idle();
    repeat (4) do_cycle();

    // Reset in the cycle after an issue discards the operation.
    bus.in_rand_valid = 1'b1;
    do_cycle();
    bus.in_rand_valid = 1'b0;
    bus.in_req_valid = 2'b10;
    rand_ops();
    do_cycle();
    chk("mid_issue", 32'(seen_ready), 32'h2);
    apply_reset();
    #1;
    chk("post_rst_rand_ready", 32'(bus.out_rand_ready), 32'd1);
    repeat (4) do_cycle();
    bus.in_req_valid = 2'b01;
    do_cycle();
    chk("post_rst_fifo_empty", 32'(seen_ready), 32'd0);
    set_idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.in_req_valid  = 2'($urandom());
      bus.in_rand_valid = ($urandom_range(0, 3) != 0);
      bus.in_res_ready  = ($urandom_range(0, 3) != 0);
      rand_ops();
      do_cycle();
    end
    set_idle();
    repeat (6) do_cycle();
    chk("drain_busy", 32'(bus.out_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/masked_mul_sched.md
MASKED_MUL_SCHED -- requirements
Module: masked_mul_sched

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2: number of shares per operand.
REQ-002 SHALL have parameter BIT_WIDTH, default 4: bits per share.
REQ-003 SHALL have parameter RAND_DEPTH, default 4: randomness FIFO entries, power of two ≥2.
REQ-004 SHALL derive NUM_QUAD = NUM_SHARES*(NUM_SHARES-1)/2 and RAND_BITS = 2*NUM_QUAD*BIT_WIDTH.
REQ-005 SHALL have port in_clock, input, 1: single clock, rising edge.
REQ-006 SHALL have port in_reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port in_req_valid, input, 2: per-requester operation valid.
REQ-008 SHALL have port out_req_ready, output, 2: per-requester accept; one-hot or zero.
REQ-009 SHALL have port in_req_a, input, 2 x NUM_SHARES x BIT_WIDTH: shared operand a per requester.
REQ-010 SHALL have port in_req_b, input, 2 x NUM_SHARES x BIT_WIDTH: shared operand b per requester.
REQ-011 SHALL have port in_rand_valid, input, 1: randomness word valid.
REQ-012 SHALL have port out_rand_ready, output, 1: randomness accept.
REQ-013 SHALL have port in_rand, input, RAND_BITS: fresh randomness; low half = r, high half = p.
REQ-014 SHALL have port out_res_valid, output, 1: result valid.
REQ-015 SHALL have port in_res_ready, input, 1: result accept.
REQ-016 SHALL have port out_res_c, output, NUM_SHARES x BIT_WIDTH: shared product.
REQ-017 SHALL have port out_res_id, output, 1: requester index of the result.
REQ-018 SHALL have port out_busy, output, 1: high while any operation is in flight or buffered.

Function
REQ-019 SHALL instantiate exactly one masked_hpc3_opt_mul (same NUM_SHARES, BIT_WIDTH) and share it between both requesters.
REQ-020 SHALL issue in cycle t only if: some in_req_valid high, randomness FIFO non-empty, and (in-flight + result-buffer occupancy − result pop in t) < 2.
REQ-021 SHALL on issue assert out_req_ready for exactly the granted requester, drive its a/b to the multiplier, and pop one FIFO entry into in_r/in_p.
REQ-022 SHALL never present a randomness entry to the multiplier in more than one issue cycle.
REQ-023 SHALL track in-flight id in a 1-bit valid/id stage; product captured from the multiplier at end of cycle t+1; out_res_valid rises in t+2 (latency 2, throughput 1/cycle).
REQ-024 SHALL buffer results in a 2-entry in-order FIFO; out_res_* held stable while out_res_valid && !in_res_ready.
REQ-025 SHALL drive out_rand_ready = !rand_full; push with simultaneous pop when full SHALL NOT occur (ready low).
REQ-026 SHALL tolerate simultaneous push and pop in non-full, non-empty FIFO states; occupancy unchanged.
REQ-027 SHALL drive undriven multiplier inputs (no issue) to all-zero operands and zero randomness.
REQ-028 SHALL assert out_busy = in-flight valid OR result buffer non-empty.

Reset
REQ-029 SHALL on in_reset low asynchronously clear: in-flight stage, result FIFO, randomness FIFO, arbiter pointer (requester 0 preferred).
REQ-030 SHALL hold out_req_ready=0, out_rand_ready=0, out_res_valid=0, out_res_c=0, out_res_id=0, out_busy=0 during reset.
REQ-031 SHALL discard, never emit, operations in flight when reset asserts mid-operation.

Configuration
REQ-032 SHALL support macro MUL_SCHED_ROUND_ROBIN_EN: defined -> round-robin, last-granted requester lowest priority next cycle; undefined -> fixed priority, requester 0 always wins.

Verification
REQ-033 SHALL cover: single op, req0 a=(0x3,0x0), b=(0x5,0x0), one rand word -> out_res_valid in t+2, id=0, XOR of shares = GF product of 3 and 5 per generic_mul.
REQ-034 SHALL cover: both requesters valid 4 cycles, FIFO full -> with RR_EN grants 0,1,0,1; without, grants 0,0,0,0.
REQ-035 SHALL cover: randomness FIFO empty with pending requests -> no out_req_ready until in_rand_valid pulse; then exactly one issue.
REQ-036 SHALL cover: in_res_ready=0 for 5 cycles with continuous requests -> exactly 2 issues, results in order, no loss, then resumes 1/cycle.
REQ-037 SHALL cover: in_reset low in cycle after issue -> no result emitted; all outputs 0; FIFO empty (out_rand_ready high after release).
